// File: rtl/md5_job_ctrl.sv
// MD5 job sequencer: streams source lines into the MD5 core, writes the digest, then the DSM completion line.
// Optional macro MD5_JOB_CTRL_PERF_EN adds a 64-bit job cycle counter reported in DSM bits [127:64].
module md5_job_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 42
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [31:0]       src_lines,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] dsm_addr,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_almfull,
  input  logic              rd_rsp_valid,
  input  logic [511:0]      rd_rsp_data,
  output logic              blk_valid,
  output logic [511:0]      blk_data,
  output logic              blk_last,
  input  logic              blk_ready,
  input  logic              dgst_valid,
  input  logic [127:0]      dgst,
  output logic              wr_req_valid,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [511:0]      wr_req_data,
  input  logic              wr_almfull,
  input  logic              wr_rsp_valid,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Handshakes: a read request is taken the cycle rd_req_valid=1 (gated by !rd_almfull);
  // a block moves on blk_valid&blk_ready; a write is taken the cycle wr_req_valid=1.
  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_DIGEST, S_WR_RES, S_WAIT_RES, S_WR_DSM, S_WAIT_DSM
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic [31:0]         src_lines_q, src_lines_d;
  logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;
  logic [ADDR_W-1:0]   dsm_addr_q, dsm_addr_d;
  logic [31:0]         issued_q, issued_d;
  logic [31:0]         consumed_q, consumed_d;
  logic [31:0]         outstanding_q, outstanding_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [127:0]        digest_q, digest_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [511:0]        fifo_mem [FIFO_DEPTH];

  logic [32:0]  credit_used;
  logic         rd_fire, push, pop, is_last, wr_fire;
  logic [63:0]  perf_field;
  logic [511:0] dsm_line;

  // Credits use registered counts only, so a response landing this cycle cannot overflow the FIFO.
  assign credit_used = {1'b0, outstanding_q} + 33'(fifo_cnt_q);
  assign rd_fire     = (state_q == S_STREAM) && (issued_q < src_lines_q) && !rd_almfull
                       && (credit_used < 33'(FIFO_DEPTH));
  assign push        = (state_q == S_STREAM) && rd_rsp_valid;
  assign blk_valid   = (state_q == S_STREAM) && (fifo_cnt_q != '0);
  assign pop         = blk_valid && blk_ready;
  assign is_last     = (consumed_q == src_lines_q - 32'd1);
  assign blk_last    = blk_valid && is_last;
  assign blk_data    = blk_valid ? fifo_mem[rd_ptr_q] : '0;

  assign rd_req_valid = rd_fire;
  assign rd_req_addr  = rd_fire ? (src_addr_q + ADDR_W'(issued_q)) : '0;

  assign wr_fire      = ((state_q == S_WR_RES) || (state_q == S_WR_DSM)) && !wr_almfull;
  assign dsm_line     = {384'b0, perf_field, src_lines_q, 30'b0, err_q, 1'b1};
  assign wr_req_valid = wr_fire;
  assign wr_req_addr  = !wr_fire ? '0 : ((state_q == S_WR_RES) ? dst_addr_q : dsm_addr_q);
  assign wr_req_data  = !wr_fire ? '0 : ((state_q == S_WR_RES) ? {384'b0, digest_q} : dsm_line);

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    state_d       = state_q;
    src_addr_d    = src_addr_q;
    src_lines_d   = src_lines_q;
    dst_addr_d    = dst_addr_q;
    dsm_addr_d    = dsm_addr_q;
    issued_d      = issued_q;
    consumed_d    = consumed_q;
    outstanding_d = outstanding_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    digest_d      = digest_q;
    err_d         = err_q;
    busy_d        = busy_q;
    done_d        = done_q;

    if (rd_fire) issued_d = issued_q + 32'd1;
    case ({rd_fire, push})
      2'b10:   outstanding_d = outstanding_q + 32'd1;
      2'b01:   outstanding_d = outstanding_q - 32'd1;
      default: outstanding_d = outstanding_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      consumed_d = consumed_q + 32'd1;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_addr_d  = src_addr;
          src_lines_d = src_lines;
          dst_addr_d  = dst_addr;
          dsm_addr_d  = dsm_addr;
          issued_d    = '0;
          consumed_d  = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = (src_lines == 32'd0);
          state_d     = (src_lines == 32'd0) ? S_WR_DSM : S_STREAM;
        end
      end
      S_STREAM:   if (pop && is_last) state_d = S_DIGEST;
      S_DIGEST: begin
        if (dgst_valid) begin
          digest_d = dgst;
          state_d  = S_WR_RES;
        end
      end
      S_WR_RES:   if (wr_fire) state_d = S_WAIT_RES;
      S_WAIT_RES: if (wr_rsp_valid) state_d = S_WR_DSM;
      S_WR_DSM:   if (wr_fire) state_d = S_WAIT_DSM;
      S_WAIT_DSM: begin
        if (wr_rsp_valid) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      src_addr_q    <= '0;
      src_lines_q   <= '0;
      dst_addr_q    <= '0;
      dsm_addr_q    <= '0;
      issued_q      <= '0;
      consumed_q    <= '0;
      outstanding_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      digest_q      <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_addr_q    <= src_addr_d;
      src_lines_q   <= src_lines_d;
      dst_addr_q    <= dst_addr_d;
      dsm_addr_q    <= dsm_addr_d;
      issued_q      <= issued_d;
      consumed_q    <= consumed_d;
      outstanding_q <= outstanding_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      digest_q      <= digest_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Line storage needs no reset: blk_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) fifo_mem[wr_ptr_q] <= rd_rsp_data;
  end

`ifdef MD5_JOB_CTRL_PERF_EN
  logic [63:0] perf_q, perf_d;

  // Runs from the accepted start until the DSM write phase begins, then holds.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && start) begin
      perf_d = '0;
    end else if (busy_q && (state_q != S_WR_DSM) && (state_q != S_WAIT_DSM)) begin
      perf_d = perf_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_field = perf_q;
`else
  assign perf_field = '0;
`endif

endmodule

// File: tb/tb_md5_job_ctrl.sv
// Directed bench for md5_job_ctrl: fabric/core model plus scoreboard queues for reads, blocks and writes.
module tb_md5_job_ctrl;

  localparam int AW = 42;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [31:0]   src_lines = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW-1:0] dsm_addr = '0;
  logic          rd_req_valid;
  logic [AW-1:0] rd_req_addr;
  logic          rd_almfull = 1'b0;
  logic          rd_rsp_valid = 1'b0;
  logic [511:0]  rd_rsp_data = '0;
  logic          blk_valid;
  logic [511:0]  blk_data;
  logic          blk_last;
  logic          blk_ready = 1'b1;
  logic          dgst_valid = 1'b0;
  logic [127:0]  dgst = '0;
  logic          wr_req_valid;
  logic [AW-1:0] wr_req_addr;
  logic [511:0]  wr_req_data;
  logic          wr_almfull = 1'b0;
  logic          wr_rsp_valid = 1'b0;
  logic          busy;
  logic          done;

  md5_job_ctrl #(.FIFO_DEPTH(8), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .src_lines(src_lines),
    .dst_addr(dst_addr), .dsm_addr(dsm_addr), .rd_req_valid(rd_req_valid),
    .rd_req_addr(rd_req_addr), .rd_almfull(rd_almfull), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_data(rd_rsp_data), .blk_valid(blk_valid), .blk_data(blk_data),
    .blk_last(blk_last), .blk_ready(blk_ready), .dgst_valid(dgst_valid), .dgst(dgst),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_almfull(wr_almfull), .wr_rsp_valid(wr_rsp_valid), .busy(busy), .done(done)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // Scoreboard state
  logic [AW-1:0] exp_rd_q[$];
  logic [511:0]  exp_blk_q[$];
  logic [AW-1:0] exp_wa_q[$];
  logic [511:0]  exp_wd_q[$];
  logic          exp_wk_q[$];
  logic [AW-1:0] rsp_q[$];

  int           checks = 0;
  int           errors = 0;
  int           rd_issued = 0;
  int           blk_idx = 0;
  logic [31:0]  cur_lines = '0;
  logic [127:0] cur_dgst = '0;
  int           start_edge = 0;
  logic [63:0]  meas_cyc = '0;
  logic         rand_af = 1'b0;
  int           dg_cnt = 0;
  int           ack_cnt = 0;
  logic         ack_dig = 1'b0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] line_of(input logic [AW-1:0] a);
    return {8{{22'h2A5A5, a}}};
  endfunction

  // Fabric and MD5 core model: drive inputs on the falling edge, then sample what the DUT will commit.
  always @(negedge clk) begin
    if (reset) begin
      rsp_q.delete();
      dg_cnt = 0;
      ack_cnt = 0;
      rd_rsp_valid = 1'b0;
      dgst_valid = 1'b0;
      wr_rsp_valid = 1'b0;
      rd_almfull = 1'b0;
      wr_almfull = 1'b0;
    end else begin
      rd_almfull = rand_af ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_almfull = rand_af ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_rsp_valid = 1'b0;
      rd_rsp_data = '0;
      if (rsp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data = line_of(rsp_q.pop_front());
      end
      dgst_valid = 1'b0;
      if (dg_cnt > 0) begin
        dg_cnt--;
        if (dg_cnt == 0) begin
          dgst_valid = 1'b1;
          dgst = cur_dgst;
        end
      end
      wr_rsp_valid = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          wr_rsp_valid = 1'b1;
          if (ack_dig) meas_cyc = 64'(edge_n + 1 - start_edge);
        end
      end
    end
    #1;
    if (!reset) begin
      if (rd_req_valid) begin
        chk("rd_almfull_quiet", 512'(rd_almfull), 512'd0);
        rd_issued++;
        chk("rd_expected", 512'(exp_rd_q.size() > 0), 512'd1);
        if (exp_rd_q.size() > 0) chk("rd_addr", 512'(rd_req_addr), 512'(exp_rd_q.pop_front()));
        rsp_q.push_back(rd_req_addr);
      end
      if (blk_valid && blk_ready) begin
        chk("blk_expected", 512'(exp_blk_q.size() > 0), 512'd1);
        if (exp_blk_q.size() > 0) chk("blk_data", blk_data, exp_blk_q.pop_front());
        chk("blk_last", 512'(blk_last), 512'(32'(blk_idx) == cur_lines - 32'd1));
        if (32'(blk_idx) == cur_lines - 32'd1) dg_cnt = 3;
        blk_idx++;
      end
      if (wr_req_valid) begin
        chk("wr_almfull_quiet", 512'(wr_almfull), 512'd0);
        chk("wr_expected", 512'(exp_wa_q.size() > 0), 512'd1);
        if (exp_wa_q.size() > 0) begin
          logic [511:0] expd;
          logic         kind;
          expd = exp_wd_q.pop_front();
          kind = exp_wk_q.pop_front();
          if (kind) begin
`ifdef MD5_JOB_CTRL_PERF_EN
            expd[127:64] = meas_cyc;
`else
            expd[127:64] = 64'd0;
`endif
          end
          chk("wr_addr", 512'(wr_req_addr), 512'(exp_wa_q.pop_front()));
          chk(kind ? "wr_dsm_data" : "wr_dgst_data", wr_req_data, expd);
          ack_dig = !kind;
        end
        ack_cnt = $urandom_range(2, 5);
      end
    end
  end

  // Driver tasks
  task automatic start_job(input logic [AW-1:0] a, input logic [31:0] n, input logic [AW-1:0] d,
                           input logic [AW-1:0] m, input logic [127:0] g);
    @(negedge clk);
    src_addr = a; src_lines = n; dst_addr = d; dsm_addr = m;
    cur_dgst = g; cur_lines = n; blk_idx = 0; rd_issued = 0; meas_cyc = '0;
    start_edge = edge_n + 1;
    for (int i = 0; i < int'(n); i++) begin
      exp_rd_q.push_back(a + AW'(i));
      exp_blk_q.push_back(line_of(a + AW'(i)));
    end
    if (n != 0) begin
      exp_wa_q.push_back(d);
      exp_wd_q.push_back({384'b0, g});
      exp_wk_q.push_back(1'b0);
    end
    exp_wa_q.push_back(m);
    exp_wd_q.push_back({384'b0, 64'b0, n, 30'b0, (n == 32'd0), 1'b1});
    exp_wk_q.push_back(1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("start_busy", 512'(busy), 512'd1);
    chk("start_done_clr", 512'(done), 512'd0);
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (k < lim && !done) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("done_timeout", 512'(done), 512'd1);
    chk("busy_clr", 512'(busy), 512'd0);
    chk("rd_q_drained", 512'(exp_rd_q.size()), 512'd0);
    chk("blk_q_drained", 512'(exp_blk_q.size()), 512'd0);
    chk("wr_q_drained", 512'(exp_wa_q.size()), 512'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd_valid"}, 512'(rd_req_valid), 512'd0);
    chk({tag, "_rd_addr"}, 512'(rd_req_addr), 512'd0);
    chk({tag, "_blk_valid"}, 512'(blk_valid), 512'd0);
    chk({tag, "_blk_last"}, 512'(blk_last), 512'd0);
    chk({tag, "_blk_data"}, blk_data, 512'd0);
    chk({tag, "_wr_valid"}, 512'(wr_req_valid), 512'd0);
    chk({tag, "_wr_addr"}, 512'(wr_req_addr), 512'd0);
    chk({tag, "_wr_data"}, wr_req_data, 512'd0);
    chk({tag, "_busy"}, 512'(busy), 512'd0);
    chk({tag, "_done"}, 512'(done), 512'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk_quiet("reset");
    @(negedge clk);
    reset = 1'b0;

    // single-line job
    start_job(42'h100, 32'd1, 42'h200, 42'h300, {4{32'hA5A5A5A5}});
    wait_done(300);
    chk("j1_blocks", 512'(blk_idx), 512'd1);

    // backpressure fills exactly FIFO_DEPTH lines; a mid-job start is ignored
    blk_ready = 1'b0;
    start_job(42'h1000, 32'd20, 42'h2000, 42'h3000, 128'h0123456789ABCDEF_FEDCBA9876543210);
    repeat (50) @(negedge clk);
    start = 1'b1; src_addr = 42'h7777; src_lines = 32'd5; dst_addr = 42'h1; dsm_addr = 42'h2;
    @(negedge clk);
    start = 1'b0;
    repeat (48) @(negedge clk);
    #2;
    chk("fill_reads", 512'(rd_issued), 512'd8);
    chk("fill_no_pop", 512'(blk_idx), 512'd0);
    @(negedge clk);
    blk_ready = 1'b1;
    wait_done(1000);
    chk("j2_blocks", 512'(blk_idx), 512'd20);
    chk("j2_reads", 512'(rd_issued), 512'd20);

    // zero-length job reports error in DSM only
    start_job(42'h4000, 32'd0, 42'h5000, 42'h6000, 128'h5);
    wait_done(300);
    chk("j3_reads", 512'(rd_issued), 512'd0);

    // address wrap under random almost-full
    rand_af = 1'b1;
    start_job(42'h3FF_FFFF_FFFE, 32'd4, 42'h7000, 42'h7100, 128'hCAFE);
    wait_done(2000);
    rand_af = 1'b0;
    chk("j4_blocks", 512'(blk_idx), 512'd4);

    // reset mid-stream, then a clean job
    start_job(42'h8000, 32'd20, 42'h8100, 42'h8200, 128'hBEEF);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    exp_rd_q.delete(); exp_blk_q.delete();
    exp_wa_q.delete(); exp_wd_q.delete(); exp_wk_q.delete();
    @(negedge clk);
    #2;
    chk_quiet("midreset");
    @(negedge clk);
    reset = 1'b0;
    start_job(42'h9000, 32'd5, 42'h9100, 42'h9200, 128'hD00D_F00D);
    wait_done(1000);
    chk("j6_blocks", 512'(blk_idx), 512'd5);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_job_ctrl.md
Name: md5_job_ctrl

Overview:
- Job sequencer for the MD5 accelerator. It sits between the CSR block (start pulse, buffer addresses and sizes, DSM base) and the MPF/CCI-P request channels.
- On start it streams a pre-padded source buffer, one 512-bit cache line per MD5 block, into the MD5 core, with bounded outstanding reads.
- It writes the 128-bit digest to the destination buffer, then writes a completion line to the DSM.
- Responses arrive in request order; MPF response sorting is enabled upstream.

Parameters:
- FIFO_DEPTH, 8: line buffer depth between read responses and the MD5 core; power of 2, at least 2.
- ADDR_W, 42: cache-line address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle job start pulse from CSR
- src_addr  in  ADDR_W  source cache-line address
- src_lines  in  32  source length in lines
- dst_addr  in  ADDR_W  digest destination line address
- dsm_addr  in  ADDR_W  DSM line address
- rd_req_valid  out  1  read request
- rd_req_addr  out  ADDR_W  read line address
- rd_almfull  in  1  read channel almost full
- rd_rsp_valid  in  1  read response
- rd_rsp_data  in  512  response line
- blk_valid  out  1  block to MD5 core
- blk_data  out  512  block data
- blk_last  out  1  final block of job
- blk_ready  in  1  core accepts block
- dgst_valid  in  1  digest valid, one-cycle pulse
- dgst  in  128  digest
- wr_req_valid  out  1  write request
- wr_req_addr  out  ADDR_W  write line address
- wr_req_data  out  512  write data
- wr_almfull  in  1  write channel almost full
- wr_rsp_valid  in  1  write acknowledge
- busy  out  1  job in progress
- done  out  1  sticky completion, cleared by next accepted start

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO, credit counter and all counters cleared.
- Reset mid-job aborts immediately with no further requests. Response and ack traffic in flight is discarded, because the fabric is reset in the same cycle.
- IDLE:
  - start latches src_addr, src_lines, dst_addr and dsm_addr; sets busy=1, done=0.
  - src_lines==0 goes to WR_DSM with err=1. Otherwise go to STREAM.
  - start while busy=1 is ignored.
- STREAM, request side:
  - Issue rd_req_valid when issued<src_lines, rd_almfull=0, and outstanding+fifo_count<FIFO_DEPTH.
  - rd_req_addr = src_addr + issued, modulo 2^ADDR_W (wrap allowed). One request per cycle maximum.
- STREAM, response side:
  - Each rd_rsp_valid pushes to the FIFO and decrements outstanding in the same cycle.
  - The FIFO head drives blk_data with blk_valid=1. A pop occurs on blk_valid&blk_ready.
  - blk_last=1 when consumed==src_lines-1.
  - After the last block pops, go to DIGEST.
- Credit accounting: simultaneous issue and response leaves outstanding unchanged. The credit check uses registered counts, so the FIFO never overflows.
- DIGEST: wait for dgst_valid, latch dgst, go to WR_RES.
- WR_RES:
  - Assert wr_req_valid when wr_almfull=0, for one cycle.
  - addr=dst_addr; data = {384'b0, digest}.
  - Go to WAIT_RES; the next wr_rsp_valid moves to WR_DSM.
- WR_DSM:
  - Assert wr_req_valid once when wr_almfull=0, with addr=dsm_addr.
  - Data: bit0=1, bit1=err, bits[63:32]=src_lines, bits[127:64] per the optional feature, rest 0.
  - Go to WAIT_DSM; wr_rsp_valid moves to IDLE with busy=0, done=1.
- Write ordering: only one write is outstanding at a time, so the digest is globally visible before the DSM flag.
- A dgst_valid or wr_rsp_valid arriving in any other state is ignored.
- Counters issued, consumed and outstanding are 32-bit unsigned. src_lines up to 2^32-1 is supported.

Optional Feature:
- Macro: MD5_JOB_CTRL_PERF_EN.
- Defined: a 64-bit cycle counter clears on accepted start, increments every cycle while busy, freezes on entry to WR_DSM, and is written to DSM bits[127:64].
- Undefined: no counter logic; DSM bits[127:64] are 0.

Test Plan:
- Sequence src_lines=1, blk_ready=1, dgst=128'hA5…: 1 read at src_addr, blk_last on first block, digest write {384'b0,dgst} to dst_addr, DSM bit0=1, bit1=0, [63:32]=1, done=1.
- src_lines=20, blk_ready=0 held for 100 cycles:
  - Exactly FIFO_DEPTH=8 reads are issued before any pop.
  - After release, all 20 blocks arrive in order.
  - blk_last only on block 19.
- src_lines=0: no reads and no digest write; DSM line with bit1=1; done=1.
- rd_almfull and wr_almfull toggled randomly; src_addr=2^42-2, src_lines=4: addresses wrap to 0 and 1; no request is issued while almfull=1.
- Reset asserted mid-STREAM, then a new start: all outputs 0 the cycle after reset; the second job completes correctly. A start pulse mid-job is ignored.
- With MD5_JOB_CTRL_PERF_EN: DSM[127:64] equals the cycle count from start to WR_DSM entry as measured by the bench. Without the macro, the field is 0.
